// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler: four packet requesters share one UART transmitter,
// with atomic packets, a tx_busy handshake timeout and a fixed inter-packet gap.
module uart_tx_scheduler #(
    parameter int GAP_CYCLES   = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [7:0]  tx_din,
    output logic        tx_wr_en,
    input  logic        tx_busy,
    output logic [3:0]  grant,
    output logic        active,
    output logic        err_timeout,
    output logic [15:0] byte_count
);

    // IDLE arbitrate | LOAD hand byte to tx | WAIT_BUSY await tx_busy | WAIT_DONE await tx idle | GAP inter-packet idle
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    localparam logic [15:0] TIMEOUT_LOAD = 16'(BUSY_TIMEOUT - 1);
    localparam logic [15:0] GAP_LOAD     = 16'(GAP_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  grant_q;
    logic [1:0]  owner_q;
    logic [1:0]  ptr_q;
    logic        last_q;
    logic        err_q;
    logic [15:0] count_q;
    logic [15:0] timer_q;

    logic [1:0]  win_idx_d;
    logic        win_found_d;
    logic [1:0]  cand;
    logic        hs;

    always_comb begin
        win_idx_d   = ptr_q;
        win_found_d = 1'b0;
        cand        = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found_d && req_valid[cand]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand;
            end
        end
    end

    assign hs        = (state_q == LOAD) && req_valid[owner_q];
    assign tx_wr_en  = hs;
    assign req_ready = hs ? grant_q : 4'b0000;

    always_comb begin
        tx_din = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (grant_q[i]) tx_din = tx_din | req_data[8*i +: 8];
        end
    end

    assign grant       = grant_q;
    assign active      = (state_q != IDLE);
    assign err_timeout = err_q;
    assign byte_count  = count_q;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= 16'h0000;
            timer_q <= 16'h0000;
        end else begin
            if (hs) count_q <= count_q + 16'd1;
            case (state_q)
                IDLE: begin
                    if (!tx_busy && win_found_d) begin
                        grant_q <= 4'b0001 << win_idx_d;
                        owner_q <= win_idx_d;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        last_q  <= req_last[owner_q];
                        timer_q <= TIMEOUT_LOAD;
                        state_q <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (timer_q == 16'h0000) begin
                        // transmitter never started: drop the rest of the packet
                        err_q   <= 1'b1;
                        grant_q <= 4'b0000;
                        ptr_q   <= owner_q + 2'd1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            grant_q <= 4'b0000;
                            ptr_q   <= owner_q + 2'd1;
                            if (GAP_CYCLES == 0) begin
                                state_q <= IDLE;
                            end else begin
                                timer_q <= GAP_LOAD;
                                state_q <= GAP;
                            end
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                GAP: begin
                    if (timer_q == 16'h0000) state_q <= IDLE;
                    else                     timer_q <= timer_q - 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 16, meaning idle clk_50m cycles inserted between packets (0 = no gap).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 8, meaning cycles allowed for tx_busy to rise after tx_wr_en.
REQ-003 The block SHALL use one clock, clk_50m; reset rst is asynchronous and active-high.
REQ-004 Ports SHALL be:
- clk_50m  in  1  system clock
- rst  in  1  async active-high reset
- req_valid  in  4  per-requester byte valid
- req_data  in  32  byte of requester i on [8i+7:8i]
- req_last  in  4  marks final byte of a packet
- req_ready  out  4  byte accepted, one-hot, combinational
- tx_din  out  8  byte to transmitter, combinational mux of granted req_data
- tx_wr_en  out  1  one-cycle write strobe to transmitter, combinational
- tx_busy  in  1  transmitter busy
- grant  out  4  one-hot current owner, 0 when none
- active  out  1  high whenever state != IDLE
- err_timeout  out  1  sticky timeout flag
- byte_count  out  16  bytes accepted since reset

Function
REQ-005 States SHALL be IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
REQ-006 In IDLE with tx_busy low and any req_valid high, the block SHALL register the round-robin winner into grant and enter LOAD next cycle; with none valid, stay in IDLE.
REQ-007 Round-robin SHALL search upward modulo 4 from the index after the last-granted requester; after reset, requester 0 has highest priority.
REQ-008 In LOAD with req_valid[g] high, tx_wr_en and req_ready[g] SHALL be 1 for exactly that cycle, tx_din = req_data[g], last flag captured, next state WAIT_BUSY.
REQ-009 In LOAD with req_valid[g] low (mid-packet stall), the block SHALL stay in LOAD holding grant, with tx_wr_en=0 and req_ready=0.
REQ-010 req_ready bits of non-granted requesters SHALL always be 0; outside LOAD, tx_wr_en=0 and req_ready=0.
REQ-011 WAIT_BUSY SHALL go to WAIT_DONE on tx_busy=1; if tx_busy stays 0 for BUSY_TIMEOUT consecutive cycles, it SHALL set err_timeout, clear grant, advance the pointer and go to IDLE (packet abandoned).
REQ-012 In WAIT_DONE on tx_busy=0: captured last=1 -> clear grant, advance pointer, go to GAP (or IDLE if GAP_CYCLES=0); last=0 -> back to LOAD with grant held.
REQ-013 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE; requests during GAP are not accepted.
REQ-014 A packet SHALL be atomic: no other requester is granted until the owner's last byte completes or a timeout occurs.
REQ-015 byte_count SHALL increment on each req_ready&req_valid handshake, wrapping 0xFFFF->0x0000.
REQ-016 err_timeout SHALL stay set until reset.
REQ-017 Request changes while not granted SHALL have no effect; req_data of the granted requester is only sampled in the handshake cycle.

Reset
REQ-018 On rst high, the block SHALL immediately force state=IDLE, grant=0, active=0, err_timeout=0, byte_count=0, pointer=requester 0; tx_wr_en and req_ready are therefore 0.
REQ-019 Reset mid-packet SHALL abandon the packet; after release the block waits in IDLE for tx_busy=0 before granting.

Verification
REQ-020 Single requester 0 sends 0xA5 with last=1 and a transmitter model (busy 1 cycle after wr_en for 10 cycles) -> one tx_wr_en with tx_din=0xA5, grant=0001, then GAP of 16 cycles, byte_count=1.
REQ-021 All four requesters valid simultaneously, 1-byte packets -> grants in order 0,1,2,3, then 0 again if still valid; a 2-byte packet from requester 1 is never interleaved with another requester's byte.
REQ-022 Requester 2 stalls req_valid low for 5 cycles mid-packet while requester 3 is valid -> grant stays 0100, no tx_wr_en until requester 2 resumes.
REQ-023 Transmitter model never raises tx_busy -> err_timeout=1 exactly 8 cycles after tx_wr_en, grant=0, state IDLE.
REQ-024 rst asserted during WAIT_DONE -> all outputs 0 in the same cycle; after release with tx_busy still 1, no grant until tx_busy=0.
REQ-025 65537 accepted bytes -> byte_count=0x0001.
